// File: rtl/move_monitor.sv
// Automated checker for one Knight move: ramp-up, heading tolerance, centre-IR
// crossing count, stop and response byte, reported as pass or a coded error.
module move_monitor #(
   parameter int                 HDG_W     = 12,
   parameter int                 FRWRD_W   = 10,
   parameter logic [HDG_W-1:0]   HDG_TOL   = 12'h02C,
   parameter logic [FRWRD_W-1:0] FRWRD_CHK = 10'h100,
   parameter int                 IR_PER_SQ = 2,
   parameter int                 TMO_W     = 26,
   parameter logic [TMO_W-1:0]   TMO       = 26'h3FF_FFFF,
   parameter logic [7:0]         ACK       = 8'hA5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [HDG_W-1:0]   exp_hdg,
   input  logic [2:0]         exp_sqrs,
   input  logic [FRWRD_W-1:0] frwrd,
   input  logic [HDG_W-1:0]   heading,
   input  logic               cntrIR_n,
   input  logic               resp_rdy,
   input  logic [7:0]         resp,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2:0]         err,
   output logic [4:0]         ir_cnt,
   output logic [HDG_W-1:0]   max_hdg_err,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RAMP = 3'd1,
      S_MOVE = 3'd2,
      S_STOP = 3'd3,
      S_ACKW = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO - TMO_W'(1);
   localparam logic [HDG_W-1:0] HDG_MIN  = {1'b1, {(HDG_W-1){1'b0}}};
   localparam logic [HDG_W-1:0] HDG_MAX  = {1'b0, {(HDG_W-1){1'b1}}};

   state_t             state, nxt_state;
   logic               ir_s1, ir_s2, ir_s3, ir_edge;
   logic [TMO_W-1:0]   timer;
   logic               tmo_hit;
   logic [4:0]         target, ir_cnt_inc;
   logic [2:0]         sq_eff;
   logic [HDG_W-1:0]   hdg_ref, hdg_diff, hdg_abs;
   logic               hdg_chk, hdg_bad;
   logic               start_acc, dec;
   logic [2:0]         dec_err;
   logic               busy_d, done_d;

   assign state_dbg = state;

   // cntrIR rising edge == falling edge of the synchronised active-low pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_s1 <= 1'b1;
         ir_s2 <= 1'b1;
         ir_s3 <= 1'b1;
      end else begin
         ir_s1 <= cntrIR_n;
         ir_s2 <= ir_s1;
         ir_s3 <= ir_s2;
      end
   end

   assign ir_edge    = ir_s3 & ~ir_s2;
   assign ir_cnt_inc = ir_cnt + 5'd1;
   assign tmo_hit    = (timer >= TMO_LAST);
   assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
   assign sq_eff     = (exp_sqrs == 3'd0) ? 3'd1 : exp_sqrs;

   // The most negative difference has no positive twin, so it saturates
   assign hdg_diff = heading - hdg_ref;
   assign hdg_abs  = (hdg_diff == HDG_MIN) ? HDG_MAX :
                     hdg_diff[HDG_W-1]    ? -hdg_diff : hdg_diff;
   assign hdg_chk  = (frwrd >= FRWRD_CHK);
   assign hdg_bad  = hdg_chk && (hdg_abs > HDG_TOL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt_state;
   end

   // Priority inside each state: heading error, IR edge / advance, timeout
   always_comb begin
      nxt_state = state;
      dec       = 1'b0;
      dec_err   = 3'd0;
      case (state)
         S_IDLE, S_DONE: nxt_state = start ? S_RAMP : S_IDLE;
         S_RAMP: begin
            if (frwrd != '0)  nxt_state = S_MOVE;
            else if (tmo_hit) begin dec = 1'b1; dec_err = 3'd1; end
         end
         S_MOVE: begin
            if (hdg_bad)      begin dec = 1'b1; dec_err = 3'd4; end
            else if (ir_edge) begin
               if (ir_cnt_inc == target) nxt_state = S_STOP;
            end
            else if (tmo_hit) begin dec = 1'b1; dec_err = 3'd2; end
         end
         S_STOP: begin
            if (ir_edge)             begin dec = 1'b1; dec_err = 3'd3; end
            else if (frwrd == '0)    nxt_state = S_ACKW;
            else if (tmo_hit)        begin dec = 1'b1; dec_err = 3'd5; end
         end
         S_ACKW: begin
            if (resp_rdy)     begin dec = 1'b1; dec_err = (resp == ACK) ? 3'd0 : 3'd6; end
            else if (tmo_hit) begin dec = 1'b1; dec_err = 3'd7; end
         end
         default: nxt_state = S_IDLE;
      endcase
      if (dec) nxt_state = S_DONE;
   end

   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (nxt_state)
         S_RAMP, S_MOVE, S_STOP, S_ACKW: busy_d = 1'b1;
         S_DONE:                         done_d = 1'b1;
         default:                        ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err         <= 3'd0;
         ir_cnt      <= 5'd0;
         max_hdg_err <= '0;
         timer       <= '0;
         target      <= 5'd0;
         hdg_ref     <= '0;
      end else begin
         busy  <= busy_d;
         done  <= done_d;
         timer <= (nxt_state != state) ? '0 : timer + TMO_W'(1);
         if (start_acc) begin
            pass        <= 1'b0;
            err         <= 3'd0;
            ir_cnt      <= 5'd0;
            max_hdg_err <= '0;
            target      <= 5'(IR_PER_SQ) * {2'b00, sq_eff};
            hdg_ref     <= exp_hdg;
         end else begin
            if ((state == S_MOVE) && hdg_chk && (hdg_abs > max_hdg_err))
               max_hdg_err <= hdg_abs;
            if ((state == S_MOVE) && ir_edge && !dec)
               ir_cnt <= ir_cnt_inc;
            if (dec) begin
               err  <= dec_err;
               pass <= (dec_err == 3'd0);
            end
         end
      end
   end

endmodule
